// File: rtl/stream_frame_checker.sv
// Frames the 0..WRAP_VALUE counter stream, checks +1 steps, and reports sum/length per frame.
// Optional FRAME_STATS_CNT_EN adds saturating clean/error record counters.
module stream_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int WRAP_VALUE = 10,
    parameter int SUM_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  ivalid,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic                  ovalid,
    input  logic                  oready,
    output logic [SUM_WIDTH-1:0]  osum,
    output logic [LEN_WIDTH-1:0]  olen,
    output logic                  oerr,
    output logic                  odrop
`ifdef FRAME_STATS_CNT_EN
    ,
    output logic [15:0]           ofrm_cnt,
    output logic [15:0]           oerr_cnt
`endif
);

    localparam logic [DATA_WIDTH-1:0] WRAP_D = DATA_WIDTH'(WRAP_VALUE);

    typedef enum logic {
        HUNT,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [SUM_WIDTH-1:0]  sum_q, sum_d, sum_inc;
    logic [LEN_WIDTH-1:0]  len_q, len_d, len_inc;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;

    logic                 emit;
    logic [SUM_WIDTH-1:0] rec_sum;
    logic [LEN_WIDTH-1:0] rec_len;
    logic                 rec_err;

    logic beat_zero;
    logic beat_match;
    logic beat_last;
    logic load;
    logic lost;

    assign beat_zero  = (idata == '0);
    assign beat_match = (idata == exp_q);
    assign beat_last  = (idata == WRAP_D);
    assign sum_inc    = sum_q + SUM_WIDTH'(idata);
    assign len_inc    = len_q + LEN_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        len_d   = len_q;
        exp_d   = exp_q;
        emit    = 1'b0;
        rec_sum = sum_q;
        rec_len = len_q;
        rec_err = 1'b0;

        if (ivalid) begin
            unique case (state_q)
                HUNT: begin
                    if (beat_zero) begin
                        state_d = RUN;
                        sum_d   = '0;
                        len_d   = LEN_WIDTH'(1);
                        exp_d   = DATA_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (!beat_match) begin
                        // Abort reports the frame as it stood before this beat.
                        emit    = 1'b1;
                        rec_err = 1'b1;
                        if (beat_zero) begin
                            sum_d = '0;
                            len_d = LEN_WIDTH'(1);
                            exp_d = DATA_WIDTH'(1);
                        end else begin
                            state_d = HUNT;
                            sum_d   = '0;
                            len_d   = '0;
                            exp_d   = '0;
                        end
                    end else if (beat_last) begin
                        emit    = 1'b1;
                        rec_sum = sum_inc;
                        rec_len = len_inc;
                        state_d = HUNT;
                        sum_d   = '0;
                        len_d   = '0;
                        exp_d   = '0;
                    end else begin
                        sum_d = sum_inc;
                        len_d = len_inc;
                        exp_d = exp_q + DATA_WIDTH'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // A held record always wins; a newer one arriving while stalled is lost.
    assign load = emit && (!ovalid || oready);
    assign lost = emit && ovalid && !oready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= HUNT;
            sum_q   <= '0;
            len_q   <= '0;
            exp_q   <= '0;
            ovalid  <= 1'b0;
            osum    <= '0;
            olen    <= '0;
            oerr    <= 1'b0;
            odrop   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            len_q   <= len_d;
            exp_q   <= exp_d;
            if (load) begin
                ovalid <= 1'b1;
                osum   <= rec_sum;
                olen   <= rec_len;
                oerr   <= rec_err;
            end else if (ovalid && oready) begin
                ovalid <= 1'b0;
            end
            if (lost) begin
                odrop <= 1'b1;
            end
        end
    end

`ifdef FRAME_STATS_CNT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ofrm_cnt <= '0;
            oerr_cnt <= '0;
        end else if (load) begin
            if (!rec_err && ofrm_cnt != 16'hFFFF) begin
                ofrm_cnt <= ofrm_cnt + 16'd1;
            end
            if (rec_err && oerr_cnt != 16'hFFFF) begin
                oerr_cnt <= oerr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
